// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline boundary: registers the memory-stage bundle, aligns load data,
// and sequences variable-latency load responses with misalignment/timeout flags.
module mem_wb_stage #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic            in_reg_write,
   input  logic            in_mem_read,
   input  logic [2:0]      in_funct3,
   input  logic [4:0]      in_rd,
   input  logic [2:0]      in_wb_sel,
   input  logic [XLEN-1:0] in_alu,
   input  logic [XLEN-1:0] in_pc4,
   input  logic [XLEN-1:0] in_imm,
   input  logic [XLEN-1:0] in_csr,
   input  logic            flush,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            stall_mem,
   output logic            wb_valid,
   output logic            wb_we,
   output logic [4:0]      wb_rd,
   output logic [2:0]      wb_sel,
   output logic [XLEN-1:0] wb_alu,
   output logic [XLEN-1:0] wb_load,
   output logic [XLEN-1:0] wb_pc4,
   output logic [XLEN-1:0] wb_imm,
   output logic [XLEN-1:0] wb_csr,
   output logic            load_misaligned,
   output logic            load_timeout,
   output logic            dbg_state
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            wb_valid_q, wb_valid_d;
   logic            wb_we_q, wb_we_d;
   logic [4:0]      wb_rd_q, wb_rd_d;
   logic [2:0]      wb_sel_q, wb_sel_d;
   logic [XLEN-1:0] wb_alu_q, wb_alu_d;
   logic [XLEN-1:0] wb_load_q, wb_load_d;
   logic [XLEN-1:0] wb_pc4_q, wb_pc4_d;
   logic [XLEN-1:0] wb_imm_q, wb_imm_d;
   logic [XLEN-1:0] wb_csr_q, wb_csr_d;
   logic            mis_q, mis_d;
   logic            to_q, to_d;

   logic            in_ok, load, misal, stall_c, capture, timeout_c, cap_we;
   logic [XLEN-1:0] cap_load;

   function automatic logic [XLEN-1:0] align_load(input logic [2:0] f3,
                                                 input logic [1:0] a,
                                                 input logic [XLEN-1:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{a, 3'b000} +: 8];
      h = w[{a[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  align_load = {{(XLEN-8){b[7]}}, b};
         3'b001:  align_load = {{(XLEN-16){h[15]}}, h};
         3'b010:  align_load = w;
         3'b100:  align_load = {{(XLEN-8){1'b0}}, b};
         3'b101:  align_load = {{(XLEN-16){1'b0}}, h};
         default: align_load = '0;
      endcase
   endfunction

   assign in_ok = in_valid & ~flush;
   assign load  = in_ok & in_mem_read;
   assign misal = load & ((((in_funct3 == 3'b001) | (in_funct3 == 3'b101)) & in_alu[0]) |
                          ((in_funct3 == 3'b010) & (in_alu[1:0] != 2'b00)));
   assign cap_we   = in_ok & in_reg_write & (in_rd != 5'd0) & ~misal;
   assign cap_load = (load & ~misal) ? align_load(in_funct3, in_alu[1:0], dmem_rdata) : '0;

   // Handshake: while stall_mem is high the MEM stage must hold every in_* input
   // stable; the bundle is consumed on the first rising edge with stall_mem low.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_c   = 1'b0;
      capture   = 1'b0;
      timeout_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load && !misal && !dmem_rvalid) begin
               state_d = S_WAIT;
               cnt_d   = '0;
               stall_c = 1'b1;
            end else begin
               capture = 1'b1;
            end
         end
         S_WAIT: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (dmem_rvalid) begin
               capture = 1'b1;
               state_d = S_IDLE;
            end else if (cnt_q < TO_C) begin
               cnt_d   = cnt_q + CW'(1);
               stall_c = 1'b1;
            end else begin
               timeout_c = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Bundle fields hold between captures; valid, write enable and pulses default low.
   always_comb begin
      wb_valid_d = 1'b0;
      wb_we_d    = 1'b0;
      mis_d      = 1'b0;
      to_d       = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_sel_d   = wb_sel_q;
      wb_alu_d   = wb_alu_q;
      wb_load_d  = wb_load_q;
      wb_pc4_d   = wb_pc4_q;
      wb_imm_d   = wb_imm_q;
      wb_csr_d   = wb_csr_q;
      if (capture || timeout_c) begin
         wb_rd_d   = in_rd;
         wb_sel_d  = in_wb_sel;
         wb_alu_d  = in_alu;
         wb_pc4_d  = in_pc4;
         wb_imm_d  = in_imm;
         wb_csr_d  = in_csr;
         wb_load_d = capture ? cap_load : '0;
      end
      if (capture) begin
         wb_valid_d = in_ok;
         wb_we_d    = cap_we;
         mis_d      = misal;
      end
      if (timeout_c) begin
         wb_valid_d = 1'b1;
         to_d       = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_rd_q    <= '0;
         wb_sel_q   <= '0;
         wb_alu_q   <= '0;
         wb_load_q  <= '0;
         wb_pc4_q   <= '0;
         wb_imm_q   <= '0;
         wb_csr_q   <= '0;
         mis_q      <= 1'b0;
         to_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wb_valid_q <= wb_valid_d;
         wb_we_q    <= wb_we_d;
         wb_rd_q    <= wb_rd_d;
         wb_sel_q   <= wb_sel_d;
         wb_alu_q   <= wb_alu_d;
         wb_load_q  <= wb_load_d;
         wb_pc4_q   <= wb_pc4_d;
         wb_imm_q   <= wb_imm_d;
         wb_csr_q   <= wb_csr_d;
         mis_q      <= mis_d;
         to_q       <= to_d;
      end
   end

   assign stall_mem       = stall_c & ~rst;
   assign wb_valid        = wb_valid_q;
   assign wb_we           = wb_we_q;
   assign wb_rd           = wb_rd_q;
   assign wb_sel          = wb_sel_q;
   assign wb_alu          = wb_alu_q;
   assign wb_load         = wb_load_q;
   assign wb_pc4          = wb_pc4_q;
   assign wb_imm          = wb_imm_q;
   assign wb_csr          = wb_csr_q;
   assign load_misaligned = mis_q;
   assign load_timeout    = to_q;
   assign dbg_state       = (state_q == S_WAIT);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed instructions push expected writebacks,
// a negedge monitor pops and compares every presented WB output.
module tb_mem_wb_stage;

   localparam int XLEN = 32;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [2:0]  sel;
      logic [31:0] alu;
      logic [31:0] load;
      logic        mis;
      logic        to;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid, in_reg_write, in_mem_read, flush, dmem_rvalid;
   logic [2:0]      in_funct3, in_wb_sel;
   logic [4:0]      in_rd;
   logic [XLEN-1:0] in_alu, in_pc4, in_imm, in_csr, dmem_rdata;
   logic            stall_mem, wb_valid, wb_we, load_misaligned, load_timeout, dbg_state;
   logic [4:0]      wb_rd;
   logic [2:0]      wb_sel;
   logic [XLEN-1:0] wb_alu, wb_load, wb_pc4, wb_imm, wb_csr;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   mem_wb_stage #(.XLEN(XLEN), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
      .in_funct3(in_funct3), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
      .in_alu(in_alu), .in_pc4(in_pc4), .in_imm(in_imm), .in_csr(in_csr),
      .flush(flush), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .stall_mem(stall_mem), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
      .wb_sel(wb_sel), .wb_alu(wb_alu), .wb_load(wb_load), .wb_pc4(wb_pc4),
      .wb_imm(wb_imm), .wb_csr(wb_csr), .load_misaligned(load_misaligned),
      .load_timeout(load_timeout), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic we, input logic [4:0] rd, input logic [2:0] sel,
                               input logic [31:0] alu, input logic [31:0] load,
                               input logic mis, input logic to);
      exp_t e;
      e.we = we; e.rd = rd; e.sel = sel; e.alu = alu; e.load = load; e.mis = mis; e.to = to;
      return e;
   endfunction

   // Issue one MEM-stage instruction and hold it until the stage accepts it.
   task automatic send(input string nm, input logic rw, input logic mr, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [2:0] sel, input logic [31:0] alu,
                       input logic [31:0] rdata, input int rv_at, input int fl_at,
                       input int exp_st, input logic push, input exp_t e);
      int st;
      bit stalled;
      bit done;
      if (push) exp_q.push_back(e);
      in_valid = 1'b1; in_reg_write = rw; in_mem_read = mr; in_funct3 = f3;
      in_rd = rd; in_wb_sel = sel; in_alu = alu;
      in_pc4 = alu ^ 32'h1111_0000; in_imm = alu ^ 32'h2222_0000; in_csr = alu ^ 32'h4444_0000;
      dmem_rdata = rdata;
      st = 0; done = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         dmem_rvalid = (c == rv_at);
         flush       = (c == fl_at);
         @(negedge clk);
         stalled = stall_mem;
         if (stalled) st++;
         @(posedge clk); #1;
         if (!stalled) done = 1'b1;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL %s_accept: still stalled after 64 cycles, required acceptance", nm);
      end
      in_valid = 1'b0; in_reg_write = 1'b0; in_mem_read = 1'b0;
      flush = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      chk({nm, "_stall_cycles"}, 32'(st), 32'(exp_st));
   endtask

   always @(negedge clk) begin
      if (!rst && (wb_valid || load_misaligned || load_timeout)) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_wb: wb_valid=%b mis=%b to=%b rd=%0d, required no output",
                     wb_valid, load_misaligned, load_timeout, wb_rd);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wb_valid", 32'(wb_valid), 32'd1);
            chk("wb_we", 32'(wb_we), 32'(mon_e.we));
            chk("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
            chk("wb_sel", 32'(wb_sel), 32'(mon_e.sel));
            chk("wb_alu", wb_alu, mon_e.alu);
            chk("wb_load", wb_load, mon_e.load);
            chk("wb_pc4", wb_pc4, mon_e.alu ^ 32'h1111_0000);
            chk("wb_imm", wb_imm, mon_e.alu ^ 32'h2222_0000);
            chk("wb_csr", wb_csr, mon_e.alu ^ 32'h4444_0000);
            chk("load_misaligned", 32'(load_misaligned), 32'(mon_e.mis));
            chk("load_timeout", 32'(load_timeout), 32'(mon_e.to));
         end
      end
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b1; in_reg_write = 1'b1; in_mem_read = 1'b1; in_funct3 = 3'b010;
      in_rd = 5'd1; in_wb_sel = 3'd0; in_alu = 32'h1000;
      in_pc4 = '0; in_imm = '0; in_csr = '0;
      flush = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      @(negedge clk);
      chk("stall_during_rst", 32'(stall_mem), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0; in_mem_read = 1'b0; in_reg_write = 1'b0;
      rst = 1'b0;
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_alu", wb_alu, 32'd0);
      chk("rst_pulses", {30'd0, load_misaligned, load_timeout}, 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);

      send("add_x5", 1, 0, 3'b000, 5'd5, 3'd0, 32'h0000_00FF, 32'h0, -1, -1, 0, 1,
           mk(1, 5'd5, 3'd0, 32'h0000_00FF, 32'h0, 0, 0));
      send("lb_wait2", 1, 1, 3'b000, 5'd6, 3'd1, 32'h0000_1003, 32'h80AA_BBCC, 2, -1, 2, 1,
           mk(1, 5'd6, 3'd1, 32'h0000_1003, 32'hFFFF_FF80, 0, 0));
      send("lbu_wait2", 1, 1, 3'b100, 5'd7, 3'd1, 32'h0000_1003, 32'h80AA_BBCC, 2, -1, 2, 1,
           mk(1, 5'd7, 3'd1, 32'h0000_1003, 32'h0000_0080, 0, 0));
      send("lw_misaligned", 1, 1, 3'b010, 5'd8, 3'd1, 32'h0000_1002, 32'h80AA_BBCC, -1, -1, 0, 1,
           mk(0, 5'd8, 3'd1, 32'h0000_1002, 32'h0, 1, 0));
      send("lw_timeout", 1, 1, 3'b010, 5'd10, 3'd1, 32'h0000_2000, 32'h1234_5678, -1, -1, 5, 1,
           mk(0, 5'd10, 3'd1, 32'h0000_2000, 32'h0, 0, 1));
      chk("timeout_state_idle", 32'(dbg_state), 32'd0);

      send("lh_flush_wait", 1, 1, 3'b001, 5'd9, 3'd1, 32'h0000_1002, 32'h80AA_BBCC, -1, 1, 1, 0,
           mk(0, 5'd0, 3'd0, 32'h0, 32'h0, 0, 0));
      dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1;
      dmem_rvalid = 1'b0; dmem_rdata = '0;
      chk("flush_state_idle", 32'(dbg_state), 32'd0);

      send("lh_hi", 1, 1, 3'b001, 5'd11, 3'd1, 32'h0000_1002, 32'h80AA_BBCC, 0, -1, 0, 1,
           mk(1, 5'd11, 3'd1, 32'h0000_1002, 32'hFFFF_80AA, 0, 0));
      send("lhu_hi", 1, 1, 3'b101, 5'd12, 3'd1, 32'h0000_1002, 32'h80AA_BBCC, 1, -1, 1, 1,
           mk(1, 5'd12, 3'd1, 32'h0000_1002, 32'h0000_80AA, 0, 0));
      send("lw_wait3", 1, 1, 3'b010, 5'd13, 3'd1, 32'h0000_1000, 32'h80AA_BBCC, 3, -1, 3, 1,
           mk(1, 5'd13, 3'd1, 32'h0000_1000, 32'h80AA_BBCC, 0, 0));
      send("lb_byte1", 1, 1, 3'b000, 5'd14, 3'd1, 32'h0000_1001, 32'h80AA_BBCC, 0, -1, 0, 1,
           mk(1, 5'd14, 3'd1, 32'h0000_1001, 32'hFFFF_FFBB, 0, 0));
      send("lh_misaligned", 1, 1, 3'b001, 5'd15, 3'd1, 32'h0000_1001, 32'h80AA_BBCC, -1, -1, 0, 1,
           mk(0, 5'd15, 3'd1, 32'h0000_1001, 32'h0, 1, 0));
      send("bad_funct3", 1, 1, 3'b011, 5'd16, 3'd1, 32'h0000_1000, 32'h80AA_BBCC, 0, -1, 0, 1,
           mk(1, 5'd16, 3'd1, 32'h0000_1000, 32'h0, 0, 0));
      send("flush_idle", 1, 0, 3'b000, 5'd18, 3'd0, 32'h0000_0033, 32'h0, -1, 0, 0, 0,
           mk(0, 5'd0, 3'd0, 32'h0, 32'h0, 0, 0));
      send("csr_sel", 1, 0, 3'b000, 5'd17, 3'd4, 32'h0000_0055, 32'h0, -1, -1, 0, 1,
           mk(1, 5'd17, 3'd4, 32'h0000_0055, 32'h0, 0, 0));
      send("addi_x0", 1, 0, 3'b000, 5'd0, 3'd0, 32'h0000_0007, 32'h0, -1, -1, 0, 1,
           mk(0, 5'd0, 3'd0, 32'h0000_0007, 32'h0, 0, 0));

      in_valid = 1'b1; in_reg_write = 1'b1; in_mem_read = 1'b1; in_funct3 = 3'b010;
      in_rd = 5'd19; in_wb_sel = 3'd1; in_alu = 32'h0000_3000;
      dmem_rvalid = 1'b0;
      @(posedge clk); #1;
      chk("midwait_state", 32'(dbg_state), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("midwait_stall_in_rst", 32'(stall_mem), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0; in_reg_write = 1'b0; in_mem_read = 1'b0;
      chk("midwait_rst_valid", {30'd0, wb_valid, wb_we}, 32'd0);
      chk("midwait_rst_alu", wb_alu, 32'd0);
      chk("midwait_rst_pulses", {30'd0, load_misaligned, load_timeout}, 32'd0);
      chk("midwait_rst_state", 32'(dbg_state), 32'd0);

      dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      dmem_rvalid = 1'b0;
      repeat (4) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
